frame_transmitter: RTL
======================

# frame_transmitter

Transmit-side counterpart of the frame aligner: it accepts payload bytes over a valid/ready handshake and buffers them in a small FIFO. Once a full payload is buffered, it emits a continuous one-byte-per-clock stream of 12-byte frames, each a 16-bit header followed by 10 payload bytes. Between frames it emits an idle byte. Its tx_data output connects directly to the aligner's byte input, so the pair can run loopback and the block can serve as an on-chip stimulus source.

## Interface
Parameters:
- PAYLOAD_LEN, 10, payload bytes per frame
- FIFO_DEPTH, 16, payload buffer depth in bytes (must be ≥ PAYLOAD_LEN)
- HDR_A, 16'hAFAA, header sent when hdr_sel=0
- HDR_B, 16'hBA55, header sent when hdr_sel=1
- IDLE_BYTE, 8'h00, inter-frame fill byte (must differ from every header byte)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept a byte
- hdr_sel  in  1  header select, sampled at frame start
- err_inject  in  1  corrupt the header of the next frame, sampled at frame start
- tx_data  out  8  serial byte stream, one byte per clk
- tx_sof  out  1  high while tx_data carries header LSB
- tx_active  out  1  high for all 12 bytes of a frame
- frame_cnt  out  16  frames fully transmitted, wraps at 2^16
- fifo_level  out  $clog2(FIFO_DEPTH+1)  bytes currently buffered

## Operation
- Push: a byte is accepted when in_valid && in_ready.
- in_ready = (fifo_level < FIFO_DEPTH), using the registered level. A same-cycle pop is not credited.
- FSM states: IDLE, HDR_LSB, HDR_MSB, PAYLOAD. A payload index counts 0..PAYLOAD_LEN-1.
- Start condition: avail ≥ PAYLOAD_LEN, where avail = fifo_level − (1 if popping this cycle). A same-cycle push is not counted.
- The start condition is evaluated in IDLE and on the last PAYLOAD byte. If true, the next state is HDR_LSB, so back-to-back frames have zero gap. If false, the next state is IDLE.
- At the start decision, hdr_sel and err_inject are latched for the whole frame.
- Header byte order is LSB first: HDR_LSB sends hdr[7:0], HDR_MSB sends hdr[15:8].
- err_inject=1 inverts bit 0 of both header bytes. For HDR_A this gives 8'hAB, 8'hAE.
- PAYLOAD pops one FIFO byte per cycle onto tx_data for PAYLOAD_LEN cycles.
- Underflow is impossible by construction, because a frame starts only once a full payload is buffered.
- frame_cnt increments in the cycle after the last payload byte is output. It is not affected by err_inject.
- FIFO ordering is strict: payload bytes leave in arrival order.

## Timing
- All outputs are registered and reflect the current state.
  - In IDLE: tx_data=IDLE_BYTE, tx_sof=0, tx_active=0.
- Reset values: state IDLE, FIFO empty, fifo_level=0, in_ready=1, tx_data=IDLE_BYTE, tx_sof=0, tx_active=0, frame_cnt=0, latched hdr_sel/err_inject=0.
- Latency: the 10th byte accepted into an empty FIFO at cycle N gives fifo_level=10 at N+1.
  - The start is decided at N+1, and header LSB appears on tx_data at N+2.
  - The last payload byte appears at N+13.
- Frame length is exactly PAYLOAD_LEN+2 cycles, and tx_active is high for all of them.
- Full FIFO: in_ready=0, and pushes are blocked even if a pop occurs that cycle.
- Simultaneous push and pop: fifo_level stays unchanged. Write and read pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: everything clears immediately (asynchronously) and buffered bytes are discarded. After deassertion the stream resumes with IDLE_BYTE.
- Changes to hdr_sel/err_inject mid-frame have no effect until the next start decision.

## Structure
- Shared package frame_pkg holds:
  - header constants HDR_A/HDR_B
  - FRAME_LEN = PAYLOAD_LEN+2
  - IDLE_BYTE
  - the FSM state enum type

  The same package is importable by the aligner bench for loopback checking.
- One sub-module, frame_tx_fifo: synchronous FIFO with push, pop, data, level and full outputs. The FSM and output registers live in frame_transmitter.

## Test plan
- Single frame: push 10 bytes 0x01..0x0A at cycles 0–9 with hdr_sel=0.
  - Expect tx_data AA, AF, 01..0A at cycles 11–22, with tx_sof at 11 only.
  - Expect frame_cnt=1 at 23 and IDLE_BYTE thereafter.
- Back-to-back: push 20 bytes continuously, with hdr_sel=1 for frame 2.
  - Expect 24 contiguous active cycles: AA AF 01..0A, then 55 BA 0B..14, with no idle gap.
- Backpressure: push 16 bytes with no pop possible, then hold in_valid.
  - Expect in_ready=0 with fifo_level=16, no byte lost or duplicated, and payload order preserved.
- Error injection: err_inject=1 at the start of frame 1 only.
  - Expect header AB AE, then clean AA AF on frame 2. frame_cnt still counts both.
- Reset mid-frame: assert reset_n=0 during payload byte 5.
  - Expect tx_data=00, tx_active=0, fifo_level=0, frame_cnt=0 immediately.
  - A fresh 10-byte push then yields a correct frame.
- Loopback: 100 random frames into the frame aligner.
  - Expect the aligner to lock within 3 frames and every payload to compare equal.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants and types for the frame transmitter and aligner.
//   PAYLOAD_LEN / FRAME_LEN : payload bytes and total bytes per frame
//   FIFO_DEPTH              : default payload buffer depth in bytes
//   HDR_A / HDR_B           : selectable 16-bit frame headers
//   IDLE_BYTE               : inter-frame fill byte
//   state_t                 : transmit FSM state encoding
//   tx_beat_t               : one byte-time of the transmit stream
package frame_pkg;

   localparam int unsigned PAYLOAD_LEN = 10;
   localparam int unsigned FRAME_LEN   = PAYLOAD_LEN + 2;
   localparam int unsigned FIFO_DEPTH  = 16;

   localparam logic [15:0] HDR_A     = 16'hAFAA;
   localparam logic [15:0] HDR_B     = 16'hBA55;
   localparam logic [7:0]  IDLE_BYTE = 8'h00;

   // Header corruption mask: bit 0 of each header byte.
   localparam logic [15:0] HDR_ERR_MASK = 16'h0101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR_LSB,
      ST_HDR_MSB,
      ST_PAYLOAD
   } state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       active;
   } tx_beat_t;

endpackage

// File: rtl/frame_tx_fifo.sv
// Synchronous payload FIFO with first-word-fall-through read data.
//   push/wr_data : write request (ignored while full)
//   pop          : read request (caller guarantees non-empty)
//   rd_data_c    : current head entry, combinational from storage
//   level        : registered occupancy
//   full         : registered, high when level == DEPTH
module frame_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rd_data_c,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full
);

   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic [LVL_W-1:0] level_d;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_ok   = push && !full;
   assign level_d   = level + LVL_W'(push_ok) - LVL_W'(pop);
   assign rd_data_c = mem[rd_ptr];

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and full flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop)     rd_ptr <= next_ptr(rd_ptr);
         level <= level_d;
         full  <= (level_d == LVL_W'(DEPTH));
      end
   end

endmodule

// File: rtl/frame_transmitter.sv
// Frame transmitter: buffers payload bytes and emits a continuous byte
// stream of [hdr LSB, hdr MSB, PAYLOAD_LEN payload bytes] frames, with
// IDLE_BYTE between frames.
//   in_data/in_valid/in_ready : payload push handshake
//   hdr_sel, err_inject       : header select / corruption, latched at start
//   tx_data/tx_sof/tx_active  : registered output stream
//   frame_cnt                 : completed frames, wraps at 2^16
//   fifo_level                : bytes currently buffered
module frame_transmitter #(
   parameter int unsigned PAYLOAD_LEN = frame_pkg::PAYLOAD_LEN,
   parameter int unsigned FIFO_DEPTH  = frame_pkg::FIFO_DEPTH,
   parameter logic [15:0] HDR_A       = frame_pkg::HDR_A,
   parameter logic [15:0] HDR_B       = frame_pkg::HDR_B,
   parameter logic [7:0]  IDLE_BYTE   = frame_pkg::IDLE_BYTE
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [7:0]                        in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              hdr_sel,
   input  logic                              err_inject,
   output logic [7:0]                        tx_data,
   output logic                              tx_sof,
   output logic                              tx_active,
   output logic [15:0]                       frame_cnt,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   import frame_pkg::*;

   localparam int unsigned      LVL_W     = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned      IDX_W     = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_LEN - 1);
   localparam logic [LVL_W-1:0] START_LVL = LVL_W'(PAYLOAD_LEN);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             sel_q, sel_d;
   logic             err_q, err_d;
   tx_beat_t         beat_q, beat_d;

   logic             fifo_full;
   logic [7:0]       fifo_rd_data_c;
   logic             pop_c;
   logic [LVL_W-1:0] avail_c;
   logic             start_c;
   logic             frame_done_c;
   logic [15:0]      hdr_c;

   frame_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (in_valid && in_ready),
      .wr_data   (in_data),
      .pop       (pop_c),
      .rd_data_c (fifo_rd_data_c),
      .level     (fifo_level),
      .full      (fifo_full)
   );

   assign in_ready = !fifo_full;

   // Outputs are registered, so the byte shown next cycle is popped now:
   // pops happen while leaving HDR_MSB and on every non-final payload byte.
   assign pop_c        = (state_q == ST_HDR_MSB) ||
                         ((state_q == ST_PAYLOAD) && (idx_q != LAST_IDX));
   assign avail_c      = fifo_level - LVL_W'(pop_c);
   assign start_c      = (avail_c >= START_LVL);
   assign frame_done_c = (state_q == ST_PAYLOAD) && (idx_q == LAST_IDX);

   // State, frame context, output registers and frame counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         sel_q     <= 1'b0;
         err_q     <= 1'b0;
         beat_q    <= '{data: IDLE_BYTE, sof: 1'b0, active: 1'b0};
         frame_cnt <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         beat_q  <= beat_d;
         if (frame_done_c) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Next-state logic; header controls are captured only at a start decision.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d = ST_HDR_LSB;
               sel_d   = hdr_sel;
               err_d   = err_inject;
            end
         end
         ST_HDR_LSB: state_d = ST_HDR_MSB;
         ST_HDR_MSB: begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
         end
         ST_PAYLOAD: begin
            if (idx_q == LAST_IDX) begin
               if (start_c) begin
                  state_d = ST_HDR_LSB;
                  sel_d   = hdr_sel;
                  err_d   = err_inject;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode for the upcoming state, registered into beat_q.
   always_comb begin
      hdr_c  = (sel_d ? HDR_B : HDR_A) ^ (err_d ? HDR_ERR_MASK : 16'h0000);
      beat_d = '{data: IDLE_BYTE, sof: 1'b0, active: 1'b0};
      unique case (state_d)
         ST_HDR_LSB: beat_d = '{data: hdr_c[7:0],    sof: 1'b1, active: 1'b1};
         ST_HDR_MSB: beat_d = '{data: hdr_c[15:8],   sof: 1'b0, active: 1'b1};
         ST_PAYLOAD: beat_d = '{data: fifo_rd_data_c, sof: 1'b0, active: 1'b1};
         default:    beat_d = '{data: IDLE_BYTE,     sof: 1'b0, active: 1'b0};
      endcase
   end

   assign tx_data   = beat_q.data;
   assign tx_sof    = beat_q.sof;
   assign tx_active = beat_q.active;

endmodule
